// File: rtl/jtag_dtm_pkg.sv
// Shared types and constants for the JTAG debug transport module and its DMI master.
package jtag_dtm_pkg;

    localparam int unsigned IrWidth      = 5;
    localparam int unsigned DmiAbits     = 7;
    localparam int unsigned DmiDataWidth = 32;
    localparam int unsigned DmiOpWidth   = 2;
    localparam int unsigned DmiDrWidth   = DmiAbits + DmiDataWidth + DmiOpWidth;

    typedef enum logic [3:0] {
        TapTlr, TapRti,
        TapSelDr, TapCapDr, TapShiftDr, TapExit1Dr, TapPauseDr, TapExit2Dr, TapUpdDr,
        TapSelIr, TapCapIr, TapShiftIr, TapExit1Ir, TapPauseIr, TapExit2Ir, TapUpdIr
    } tap_state_e;

    typedef enum logic [1:0] {
        DmiIdle,
        DmiReq,
        DmiWait
    } dmi_fsm_e;

    localparam logic [IrWidth-1:0] IrIdcode = 5'h01;
    localparam logic [IrWidth-1:0] IrDtmcs  = 5'h10;
    localparam logic [IrWidth-1:0] IrDmi    = 5'h11;
    localparam logic [IrWidth-1:0] IrBypass = 5'h1F;

    localparam logic [DmiOpWidth-1:0] DmiOpRead   = 2'd1;
    localparam logic [DmiOpWidth-1:0] DmiOpWrite  = 2'd2;
    localparam logic [1:0]            DmiStatOk   = 2'd0;
    localparam logic [1:0]            DmiStatFail = 2'd2;
    localparam logic [1:0]            DmiStatBusy = 2'd3;

    // DMI data register layout, MSB first: addr, data, op
    typedef struct packed {
        logic [DmiAbits-1:0]     addr;
        logic [DmiDataWidth-1:0] data;
        logic [DmiOpWidth-1:0]   op;
    } dmi_dr_t;

    function automatic logic [31:0] dtmcs_word(input logic [1:0] dmistat);
        return {14'b0, 3'b000, 3'd1, dmistat, 6'(DmiAbits), 4'd1};
    endfunction

endpackage

// File: rtl/jtag_tap_sync.sv
// Brings the asynchronous JTAG pins into the system clock domain and detects tck edges.
module jtag_tap_sync #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clock,
    input  logic reset_ni,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    input  logic trst_n,
    output logic tms_s,
    output logic tdi_s,
    output logic trst_n_s,
    output logic tck_rise_c,
    output logic tck_fall_c
);

    logic [SyncStages-1:0] tck_q, tms_q, tdi_q, trst_q;
    logic                  tck_d;

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            tck_q  <= '0;
            tms_q  <= '0;
            tdi_q  <= '0;
            trst_q <= '0;
            tck_d  <= 1'b0;
        end else begin
            tck_q  <= {tck_q[SyncStages-2:0], tck};
            tms_q  <= {tms_q[SyncStages-2:0], tms};
            tdi_q  <= {tdi_q[SyncStages-2:0], tdi};
            trst_q <= {trst_q[SyncStages-2:0], trst_n};
            tck_d  <= tck_q[SyncStages-1];
        end
    end

    assign tms_s      = tms_q[SyncStages-1];
    assign tdi_s      = tdi_q[SyncStages-1];
    assign trst_n_s   = trst_q[SyncStages-1];
    assign tck_rise_c = tck_q[SyncStages-1] & ~tck_d;
    assign tck_fall_c = ~tck_q[SyncStages-1] & tck_d;

endmodule

// File: rtl/jtag_dmi_bridge.sv
// Oversampled JTAG DTM: TAP controller, IDCODE/DTMCS/DMI/BYPASS registers and a DMI request master.
module jtag_dmi_bridge
    import jtag_dtm_pkg::*;
#(
    parameter logic [31:0] IdcodeValue = 32'h04F5484D,
    parameter int unsigned SyncStages  = 2
) (
    input  logic                    clock,
    input  logic                    reset_ni,
    input  logic                    jtag_tck_i,
    input  logic                    jtag_tms_i,
    input  logic                    jtag_tdi_i,
    input  logic                    jtag_trst_ni,
    output logic                    jtag_tdo_o,
    output logic                    dmi_req_valid,
    input  logic                    dmi_req_ready,
    output logic [DmiAbits-1:0]     dmi_req_addr,
    output logic [DmiOpWidth-1:0]   dmi_req_op,
    output logic [DmiDataWidth-1:0] dmi_req_data,
    input  logic                    dmi_rsp_valid,
    output logic                    dmi_rsp_ready,
    input  logic [DmiDataWidth-1:0] dmi_rsp_data,
    input  logic [1:0]              dmi_rsp_resp,
    output logic                    dmi_rst_n
);

    logic tms_s, tdi_s, trst_n_s, tck_rise, tck_fall;

    jtag_tap_sync #(.SyncStages(SyncStages)) u_sync (
        .clock      (clock),
        .reset_ni   (reset_ni),
        .tck        (jtag_tck_i),
        .tms        (jtag_tms_i),
        .tdi        (jtag_tdi_i),
        .trst_n     (jtag_trst_ni),
        .tms_s      (tms_s),
        .tdi_s      (tdi_s),
        .trst_n_s   (trst_n_s),
        .tck_rise_c (tck_rise),
        .tck_fall_c (tck_fall)
    );

    tap_state_e tap_q, tap_d;
    logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni)      tap_q <= TapTlr;
        else if (!trst_n_s) tap_q <= TapTlr;
        else if (tck_rise)  tap_q <= tap_d;
    end

    always_comb begin
        tap_d = tap_q;
        case (tap_q)
            TapTlr:     tap_d = tms_s ? TapTlr     : TapRti;
            TapRti:     tap_d = tms_s ? TapSelDr   : TapRti;
            TapSelDr:   tap_d = tms_s ? TapSelIr   : TapCapDr;
            TapCapDr:   tap_d = tms_s ? TapExit1Dr : TapShiftDr;
            TapShiftDr: tap_d = tms_s ? TapExit1Dr : TapShiftDr;
            TapExit1Dr: tap_d = tms_s ? TapUpdDr   : TapPauseDr;
            TapPauseDr: tap_d = tms_s ? TapExit2Dr : TapPauseDr;
            TapExit2Dr: tap_d = tms_s ? TapUpdDr   : TapShiftDr;
            TapUpdDr:   tap_d = tms_s ? TapSelDr   : TapRti;
            TapSelIr:   tap_d = tms_s ? TapTlr     : TapCapIr;
            TapCapIr:   tap_d = tms_s ? TapExit1Ir : TapShiftIr;
            TapShiftIr: tap_d = tms_s ? TapExit1Ir : TapShiftIr;
            TapExit1Ir: tap_d = tms_s ? TapUpdIr   : TapPauseIr;
            TapPauseIr: tap_d = tms_s ? TapExit2Ir : TapPauseIr;
            TapExit2Ir: tap_d = tms_s ? TapUpdIr   : TapShiftIr;
            TapUpdIr:   tap_d = tms_s ? TapSelDr   : TapRti;
        endcase
    end

    // Register actions fire on the tck rise that leaves the corresponding state
    always_comb begin
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        if (tck_rise && trst_n_s) begin
            case (tap_q)
                TapCapDr:   capture_dr = 1'b1;
                TapShiftDr: shift_dr   = 1'b1;
                TapUpdDr:   update_dr  = 1'b1;
                TapCapIr:   capture_ir = 1'b1;
                TapShiftIr: shift_ir   = 1'b1;
                TapUpdIr:   update_ir  = 1'b1;
                default: ;
            endcase
        end
    end

    logic [IrWidth-1:0] ir_q, ir_sr_q;

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            ir_q    <= IrIdcode;
            ir_sr_q <= '0;
        end else begin
            if (capture_ir)    ir_sr_q <= 5'b00001;
            else if (shift_ir) ir_sr_q <= {tdi_s, ir_sr_q[IrWidth-1:1]};
            if (!trst_n_s || tap_q == TapTlr) ir_q <= IrIdcode;
            else if (update_ir)               ir_q <= ir_sr_q;
        end
    end

    dmi_fsm_e dmi_q, dmi_d;
    logic [DmiDrWidth-1:0]   dr_q, dr_shifted;
    dmi_dr_t                 dr_dmi;
    logic [DmiAbits-1:0]     req_addr_q;
    logic [DmiDataWidth-1:0] req_data_q, last_rdata_q;
    logic [DmiOpWidth-1:0]   req_op_q;
    logic [1:0]              sticky_q, dmi_status;
    logic upd_dtmcs, upd_dmi, hardreset, dmireset, busy_eff, dmi_accept, rsp_fire;

    assign dr_dmi     = dmi_dr_t'(dr_q);
    assign dmi_status = (dmi_q != DmiIdle) ? DmiStatBusy : sticky_q;
    assign upd_dtmcs  = update_dr && (ir_q == IrDtmcs);
    assign upd_dmi    = update_dr && (ir_q == IrDmi);
    assign hardreset  = upd_dtmcs && dr_q[17];
    assign dmireset   = upd_dtmcs && dr_q[16];
    // A response arriving in the same cycle frees the FSM for a new request
    assign busy_eff   = (dmi_q == DmiReq) || ((dmi_q == DmiWait) && !dmi_rsp_valid);
    assign dmi_accept = upd_dmi && ((dr_dmi.op == DmiOpRead) || (dr_dmi.op == DmiOpWrite))
                        && (sticky_q == DmiStatOk) && !busy_eff;
    assign rsp_fire   = (dmi_q == DmiWait) && dmi_rsp_valid && !hardreset;

    // Serial data enters at the MSB of whichever register is selected
    always_comb begin
        dr_shifted = {1'b0, dr_q[DmiDrWidth-1:1]};
        case (ir_q)
            IrIdcode, IrDtmcs: dr_shifted[31]            = tdi_s;
            IrDmi:             dr_shifted[DmiDrWidth-1] = tdi_s;
            default:           dr_shifted[0]            = tdi_s;
        endcase
    end

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            dr_q <= '0;
        end else if (capture_dr) begin
            case (ir_q)
                IrIdcode: dr_q <= DmiDrWidth'(IdcodeValue);
                IrDtmcs:  dr_q <= DmiDrWidth'(dtmcs_word(dmi_status));
                IrDmi:    dr_q <= {req_addr_q, last_rdata_q, dmi_status};
                default:  dr_q <= '0;
            endcase
        end else if (shift_dr) begin
            dr_q <= dr_shifted;
        end
    end

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_op_q     <= '0;
            last_rdata_q <= '0;
            sticky_q     <= DmiStatOk;
            dmi_rst_n    <= 1'b1;
        end else begin
            dmi_rst_n <= !hardreset;
            if (dmi_accept) begin
                req_addr_q <= dr_dmi.addr;
                req_data_q <= dr_dmi.data;
                req_op_q   <= dr_dmi.op;
            end
            if (rsp_fire && req_op_q == DmiOpRead) last_rdata_q <= dmi_rsp_data;
            // Sticky status holds its first error until dmireset
            if (dmireset) begin
                sticky_q <= DmiStatOk;
            end else if (sticky_q == DmiStatOk) begin
                if (upd_dmi && busy_eff)                         sticky_q <= DmiStatBusy;
                else if (rsp_fire && dmi_rsp_resp != DmiStatOk) sticky_q <= DmiStatFail;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) dmi_q <= DmiIdle;
        else           dmi_q <= dmi_d;
    end

    always_comb begin
        dmi_d = dmi_q;
        if (hardreset) begin
            dmi_d = DmiIdle;
        end else begin
            case (dmi_q)
                DmiIdle: if (dmi_accept)    dmi_d = DmiReq;
                DmiReq:  if (dmi_req_ready) dmi_d = DmiWait;
                DmiWait: if (dmi_rsp_valid) dmi_d = dmi_accept ? DmiReq : DmiIdle;
                default: dmi_d = DmiIdle;
            endcase
        end
    end

    always_comb begin
        dmi_req_valid = 1'b0;
        dmi_rsp_ready = 1'b0;
        case (dmi_q)
            DmiReq:  dmi_req_valid = 1'b1;
            DmiWait: dmi_rsp_ready = 1'b1;
            default: ;
        endcase
    end

    assign dmi_req_addr = req_addr_q;
    assign dmi_req_op   = req_op_q;
    assign dmi_req_data = req_data_q;

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            jtag_tdo_o <= 1'b0;
        end else if (!trst_n_s) begin
            jtag_tdo_o <= 1'b0;
        end else if (tck_fall) begin
            case (tap_q)
                TapShiftIr: jtag_tdo_o <= ir_sr_q[0];
                TapShiftDr: jtag_tdo_o <= dr_q[0];
                default:    jtag_tdo_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_dmi_bridge.sv
// Directed bench for jtag_dmi_bridge: bit-banged JTAG plus a hand-driven DMI target.
module tb_jtag_dmi_bridge;

    logic        clock = 1'b0;
    logic        reset_ni = 1'b0;
    logic        tck = 1'b0, tms = 1'b1, tdi = 1'b0, trst_n = 1'b1;
    logic        tdo;
    logic        dmi_req_valid, dmi_req_ready = 1'b0;
    logic [6:0]  dmi_req_addr;
    logic [1:0]  dmi_req_op;
    logic [31:0] dmi_req_data;
    logic        dmi_rsp_valid = 1'b0, dmi_rsp_ready;
    logic [31:0] dmi_rsp_data = '0;
    logic [1:0]  dmi_rsp_resp = '0;
    logic        dmi_rst_n;

    int checks = 0;
    int errors = 0;
    int rst_low_cnt = 0;
    int cnt0;
    logic [40:0] d;
    logic [4:0]  ir_cap;

    jtag_dmi_bridge dut (
        .clock         (clock),
        .reset_ni      (reset_ni),
        .jtag_tck_i    (tck),
        .jtag_tms_i    (tms),
        .jtag_tdi_i    (tdi),
        .jtag_trst_ni  (trst_n),
        .jtag_tdo_o    (tdo),
        .dmi_req_valid (dmi_req_valid),
        .dmi_req_ready (dmi_req_ready),
        .dmi_req_addr  (dmi_req_addr),
        .dmi_req_op    (dmi_req_op),
        .dmi_req_data  (dmi_req_data),
        .dmi_rsp_valid (dmi_rsp_valid),
        .dmi_rsp_ready (dmi_rsp_ready),
        .dmi_rsp_data  (dmi_rsp_data),
        .dmi_rsp_resp  (dmi_rsp_resp),
        .dmi_rst_n     (dmi_rst_n)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (dmi_rst_n === 1'b0) rst_low_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic jtag_bit(input logic t_ms, input logic t_di, output logic t_do);
        tms = t_ms;
        tdi = t_di;
        wait_clk(3);
        t_do = tdo;
        tck = 1'b1;
        wait_clk(6);
        tck = 1'b0;
        wait_clk(6);
    endtask

    task automatic tap_reset();
        logic x;
        for (int i = 0; i < 5; i++) jtag_bit(1'b1, 1'b0, x);
        jtag_bit(1'b0, 1'b0, x);
    endtask

    task automatic shift_ir(input logic [4:0] val, output logic [4:0] cap);
        logic x;
        cap = '0;
        jtag_bit(1'b1, 1'b0, x);
        jtag_bit(1'b1, 1'b0, x);
        jtag_bit(1'b0, 1'b0, x);
        jtag_bit(1'b0, 1'b0, x);
        for (int i = 0; i < 5; i++) jtag_bit(i == 4, val[i], cap[i]);
        jtag_bit(1'b1, 1'b0, x);
        jtag_bit(1'b0, 1'b0, x);
    endtask

    task automatic shift_dr(input logic [40:0] din, input int len, output logic [40:0] dout);
        logic x;
        dout = '0;
        jtag_bit(1'b1, 1'b0, x);
        jtag_bit(1'b0, 1'b0, x);
        jtag_bit(1'b0, 1'b0, x);
        for (int i = 0; i < len; i++) jtag_bit(i == len - 1, din[i], dout[i]);
        jtag_bit(1'b1, 1'b0, x);
        jtag_bit(1'b0, 1'b0, x);
    endtask

    task automatic accept_req();
        int n = 0;
        while (dmi_req_valid !== 1'b1 && n < 100) begin
            wait_clk(1);
            n++;
        end
        check("req_valid_seen", 64'(dmi_req_valid), 64'h1);
        dmi_req_ready = 1'b1;
        wait_clk(1);
        dmi_req_ready = 1'b0;
        check("rsp_ready_after_hs", 64'(dmi_rsp_ready), 64'h1);
    endtask

    task automatic give_rsp(input logic [31:0] rdata, input logic [1:0] resp);
        dmi_rsp_data  = rdata;
        dmi_rsp_resp  = resp;
        dmi_rsp_valid = 1'b1;
        wait_clk(1);
        dmi_rsp_valid = 1'b0;
        check("rsp_ready_after_rsp", 64'(dmi_rsp_ready), 64'h0);
    endtask

    initial begin
        wait_clk(3);
        reset_ni = 1'b1;
        wait_clk(5);
        check("rst_tdo", 64'(tdo), 64'h0);
        check("rst_req_valid", 64'(dmi_req_valid), 64'h0);
        check("rst_rsp_ready", 64'(dmi_rsp_ready), 64'h0);
        check("rst_addr", 64'(dmi_req_addr), 64'h0);
        check("rst_op", 64'(dmi_req_op), 64'h0);
        check("rst_data", 64'(dmi_req_data), 64'h0);
        check("rst_dmi_rst_n", 64'(dmi_rst_n), 64'h1);

        // IDCODE after TLR
        tap_reset();
        shift_dr(41'h0, 32, d);
        check("idcode", 64'(d[31:0]), 64'h04F5484D);

        // DTMCS read
        shift_ir(5'h10, ir_cap);
        check("ir_capture", 64'(ir_cap), 64'h01);
        shift_dr(41'h0, 32, d);
        check("dtmcs_idle", 64'(d[31:0]), 64'h00001071);

        // BYPASS delays tdi by one bit
        shift_ir(5'h1F, ir_cap);
        shift_dr(41'hA5, 8, d);
        check("bypass", 64'(d[7:0]), 64'h4A);

        // DMI write with stalled ready
        shift_ir(5'h11, ir_cap);
        shift_dr({7'h10, 32'h00000001, 2'd2}, 41, d);
        check("wr_valid", 64'(dmi_req_valid), 64'h1);
        check("wr_addr", 64'(dmi_req_addr), 64'h10);
        check("wr_op", 64'(dmi_req_op), 64'h2);
        check("wr_data", 64'(dmi_req_data), 64'h1);
        for (int i = 0; i < 3; i++) begin
            wait_clk(1);
            check("wr_valid_held", 64'(dmi_req_valid), 64'h1);
            check("wr_addr_held", 64'(dmi_req_addr), 64'h10);
        end
        accept_req();
        give_rsp(32'h12345678, 2'd0);
        shift_dr(41'h0, 41, d);
        check("wr_cap_status", 64'(d[1:0]), 64'h0);
        check("wr_cap_addr", 64'(d[40:34]), 64'h10);
        check("wr_cap_rdata", 64'(d[33:2]), 64'h0);
        check("nop_no_req", 64'(dmi_req_valid), 64'h0);

        // DMI read
        shift_dr({7'h11, 32'h0, 2'd1}, 41, d);
        check("rd_op", 64'(dmi_req_op), 64'h1);
        accept_req();
        give_rsp(32'hDEADBEEF, 2'd0);
        shift_dr(41'h0, 41, d);
        check("rd_cap_data", 64'(d[33:2]), 64'hDEADBEEF);
        check("rd_cap_status", 64'(d[1:0]), 64'h0);
        check("rd_cap_addr", 64'(d[40:34]), 64'h11);

        // Update while response outstanding
        shift_dr({7'h12, 32'h0, 2'd1}, 41, d);
        accept_req();
        shift_dr({7'h13, 32'h0, 2'd1}, 41, d);
        check("busy_cap_status", 64'(d[1:0]), 64'h3);
        check("busy_no_new_req", 64'(dmi_req_valid), 64'h0);
        check("busy_still_wait", 64'(dmi_rsp_ready), 64'h1);
        check("busy_addr_kept", 64'(dmi_req_addr), 64'h12);
        give_rsp(32'h0BADF00D, 2'd0);
        shift_dr(41'h0, 41, d);
        check("sticky_busy", 64'(d[1:0]), 64'h3);
        check("busy_rd_data", 64'(d[33:2]), 64'h0BADF00D);
        shift_ir(5'h10, ir_cap);
        shift_dr(41'h1_0000, 32, d);
        check("dtmcs_busy", 64'(d[31:0]), 64'h00001C71);
        shift_dr(41'h0, 32, d);
        check("dtmcs_cleared", 64'(d[31:0]), 64'h00001071);

        // Error response sets sticky fail
        shift_ir(5'h11, ir_cap);
        shift_dr({7'h14, 32'h0, 2'd1}, 41, d);
        accept_req();
        give_rsp(32'hCAFE0000, 2'd2);
        shift_dr(41'h0, 41, d);
        check("fail_status", 64'(d[1:0]), 64'h2);
        check("fail_rdata", 64'(d[33:2]), 64'hCAFE0000);
        shift_dr({7'h15, 32'h0, 2'd1}, 41, d);
        wait_clk(20);
        check("sticky_blocks_req", 64'(dmi_req_valid), 64'h0);
        shift_dr(41'h0, 41, d);
        check("sticky_kept", 64'(d[1:0]), 64'h2);
        check("sticky_addr_kept", 64'(d[40:34]), 64'h14);

        // dmireset then hardreset abort of a pending request
        shift_ir(5'h10, ir_cap);
        shift_dr(41'h1_0000, 32, d);
        check("dtmcs_fail", 64'(d[31:0]), 64'h00001871);
        shift_ir(5'h11, ir_cap);
        shift_dr({7'h16, 32'h0, 2'd1}, 41, d);
        check("pending_valid", 64'(dmi_req_valid), 64'h1);
        shift_ir(5'h10, ir_cap);
        cnt0 = rst_low_cnt;
        shift_dr(41'h2_0000, 32, d);
        check("dtmcs_pending", 64'(d[31:0]), 64'h00001C71);
        check("hardreset_pulse", 64'(rst_low_cnt - cnt0), 64'h1);
        check("hardreset_idle_req", 64'(dmi_req_valid), 64'h0);
        check("hardreset_idle_rsp", 64'(dmi_rsp_ready), 64'h0);
        check("hardreset_rst_n_high", 64'(dmi_rst_n), 64'h1);

        // TRST returns IR to IDCODE
        shift_ir(5'h11, ir_cap);
        trst_n = 1'b0;
        wait_clk(10);
        trst_n = 1'b1;
        wait_clk(10);
        check("trst_tdo", 64'(tdo), 64'h0);
        jtag_bit(1'b0, 1'b0, d[0]);
        shift_dr(41'h0, 32, d);
        check("trst_idcode", 64'(d[31:0]), 64'h04F5484D);

        // System reset in the middle of a request
        shift_ir(5'h11, ir_cap);
        shift_dr({7'h17, 32'h00000005, 2'd2}, 41, d);
        check("mid_valid", 64'(dmi_req_valid), 64'h1);
        reset_ni = 1'b0;
        #1;
        check("mid_rst_valid", 64'(dmi_req_valid), 64'h0);
        check("mid_rst_addr", 64'(dmi_req_addr), 64'h0);
        check("mid_rst_data", 64'(dmi_req_data), 64'h0);
        check("mid_rst_dmi_rst_n", 64'(dmi_rst_n), 64'h1);
        wait_clk(2);
        reset_ni = 1'b1;
        wait_clk(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_dmi_bridge.md
Name: jtag_dmi_bridge

Overview:
- Single-clock JTAG Debug Transport Module (DTM) sitting upstream of the debug module's DMI port in azadi_soc_top.
- Alternative to the DPI DMI driver when DirectDmiTap = 0: an external JTAG probe or jtagdpi drives it, and it issues DMI requests and collects DMI responses.
- TCK is oversampled in the system clock domain, so the block contains no TCK-clocked flops.

Parameters:
- IdcodeValue, 32'h04F5484D, value shifted out of IDCODE; bit 0 must be 1.
- SyncStages, 2, synchronizer depth on tck/tms/tdi/trst_n; legal range 2..3.

Ports:
- clock  in  1  system clock
- reset_ni  in  1  async active-low reset
- jtag_tck_i  in  1  JTAG clock, asynchronous
- jtag_tms_i  in  1  mode select
- jtag_tdi_i  in  1  data in
- jtag_trst_ni  in  1  async TAP reset, active-low
- jtag_tdo_o  out  1  data out
- dmi_req_valid  out  1  request valid
- dmi_req_ready  in  1  DM accepts request
- dmi_req_addr  out  7  DMI address
- dmi_req_op  out  2  1 = read, 2 = write
- dmi_req_data  out  32  write data
- dmi_rsp_valid  in  1  response valid
- dmi_rsp_ready  out  1  bridge accepts response
- dmi_rsp_data  in  32  read data
- dmi_rsp_resp  in  2  0 = ok, else error
- dmi_rst_n  out  1  DMI reset to DM, active-low

Behaviour:
- Reset values: all outputs 0 except dmi_rst_n = 1. TAP = Test-Logic-Reset, IR = 5'h01, sticky status = 0, DMI FSM = IDLE.
- Sampling:
  - tck, tms, tdi and trst_n each pass through SyncStages flops.
  - rise = synced tck 0→1; fall = synced tck 1→0; detection takes one cycle after the synchronizer.
  - Required TCK high and low time: ≥ SyncStages+2 clocks.
- TAP:
  - Standard 16-state IEEE 1149.1 FSM, advanced on rise using synced tms.
  - Synced trst_n = 0 forces Test-Logic-Reset and IR = IDCODE.
  - Five tms = 1 rises also reach Test-Logic-Reset.
- IR: 5 bits. Capture-IR loads 5'b00001; shifts LSB-first. Decode: 01 IDCODE, 10 DTMCS, 11 DMI; all other values select BYPASS.
- Data registers:
  - IDCODE: 32 bits, captures IdcodeValue.
  - BYPASS: 1 bit, captures 0.
  - DTMCS: 32 bits, captures {14'b0, dmihardreset=0, dmireset=0, 1'b0, idle=3'd1, dmistat[1:0], abits=6'd7, version=4'd1}.
  - DTMCS Update-DR: bit16 = 1 clears sticky status; bit17 = 1 aborts the DMI FSM to IDLE and pulses dmi_rst_n low for exactly 1 clock.
  - DMI: 41 bits {addr[40:34], data[33:2], op[1:0]}. Capture-DR loads {last_addr, last_rdata, status}; status = 3 if the FSM is not IDLE, else sticky.
  - DMI Update-DR with op ∈ {1,2}, sticky = 0 and FSM IDLE: latch addr/data/op and go to REQ.
  - DMI Update-DR while FSM not IDLE: sticky ← 3, request dropped.
  - DMI Update-DR with op ∈ {0,3}, or with sticky ≠ 0: no request issued.
- Shift path: Shift-DR/IR shifts right on rise, tdi enters at MSB.
- TDO: jtag_tdo_o updates on fall with the LSB of the selected shift register during Shift-IR/DR; otherwise 0.
- DMI FSM:
  - IDLE: dmi_req_valid = 0, dmi_rsp_ready = 0.
  - REQ: dmi_req_valid = 1; addr/op/data held stable until dmi_req_ready. On the valid&ready cycle go to WAIT.
  - WAIT: dmi_rsp_ready = 1. On dmi_rsp_valid latch rdata (reads only) and go to IDLE. If resp ≠ 0 and sticky = 0, set sticky ← 2.
- Boundary cases:
  - Hardreset in the same cycle as a handshake: hardreset wins.
  - Sticky is never overwritten once nonzero, except by dmireset.
  - reset_ni assert mid-transaction: everything returns to reset values immediately.
  - A new Update-DR accepted on the cycle the FSM returns to IDLE counts as not busy.

Decomposition:
- Package jtag_dtm_pkg:
  - tap_state_e (16 states); dmi_fsm_e (IDLE/REQ/WAIT).
  - IR codes (IrIdcode, IrDtmcs, IrDmi, IrBypass).
  - DmiOpRead = 1, DmiOpWrite = 2; DmiAbits = 7; DmiStatBusy = 3, DmiStatFail = 2.
- Sub-module jtag_tap_sync: SyncStages synchronizer plus tck rise/fall edge detector.
- TAP FSM, register file and DMI FSM stay in the top.

Test Plan:
- Reset, select IDCODE via TLR, shift 32 bits → tdo stream equals 32'h04F5484D LSB-first.
- IR = 5'h10, shift DR → 32'h00001071. IR = 5'h1F, shift 8 bits → tdo is input delayed by one bit.
- DMI write addr 7'h10, data 32'h00000001, op 2 → dmi_req {10,2,1}, valid held through 3 cycles of dmi_req_ready = 0. Next capture → status 0.
- DMI read addr 7'h11, response data 32'hDEADBEEF, resp 0 → following capture returns data 32'hDEADBEEF, status 0.
- Stall dmi_rsp_valid and issue a second Update-DR → capture status 3, no second request. DTMCS write bit16 → status 0.
- Response resp = 2 → sticky 2. DTMCS bit17 write → dmi_rst_n low exactly 1 clock, FSM IDLE. jtag_trst_ni low → IR reads back IDCODE.
